// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one byte-addressed data memory between two requesters.
// It arbitrates one access per cycle, checks range and alignment, and returns a registered response.
module dmem_arbiter #(
  parameter int DEPTH     = 16384,
  parameter bit RR_EN     = 1'b1,
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [2:0]  p0_req_funct3,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [2:0]  p1_req_funct3,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_instr,
  input  logic [31:0] mem_rdata
);
  logic        rr_q, rr_d;
  logic        v0_q, v0_d, e0_q, e0_d, v1_q, v1_d, e1_q, e1_d;
  logic [31:0] d0_q, d0_d, d1_q, d1_d;
  logic        g0, g1, any, we, f3_ok, in_rng, algn, ok;
  logic [2:0]  f3, sz;
  logic [31:0] addr, wdata;
  always_comb begin
    // rr_q = 1 hands the tie to port 1; grants are suppressed while in reset
    g1     = rst_n & p1_req_valid & (~p0_req_valid | (RR_EN & rr_q));
    g0     = rst_n & p0_req_valid & ~g1;
    any    = g0 | g1;
    we     = g1 ? p1_req_we : p0_req_we;
    f3     = g1 ? p1_req_funct3 : p0_req_funct3;
    addr   = g1 ? p1_req_addr : p0_req_addr;
    wdata  = g1 ? p1_req_wdata : p0_req_wdata;
    sz     = f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
    f3_ok  = (f3[1:0] != 2'b11) & (we ? ~f3[2] : ~(f3[2] & f3[1]));
    in_rng = ({1'b0, addr} + {30'b0, sz}) <= 33'(DEPTH);
    algn   = f3[1] ? (addr[1:0] == 2'b00) : f3[0] ? ~addr[0] : 1'b1;
    ok     = f3_ok & in_rng & (algn | ~ALIGN_CHK);
    mem_read  = any & ~we & ok;
    mem_write = any & we & ok;
    mem_addr  = any ? addr : '0;
    mem_wdata = any ? wdata : '0;
    mem_instr = any ? {17'b0, f3, 12'b0} : '0;
    p0_req_ready = g0;
    p1_req_ready = g1;
    rr_d = g0 ? 1'b1 : g1 ? 1'b0 : rr_q;
    v0_d = g0;
    e0_d = g0 & ~ok;
    d0_d = (g0 & mem_read) ? mem_rdata : '0;
    v1_d = g1;
    e1_d = g1 & ~ok;
    d1_d = (g1 & mem_read) ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_q <= 1'b0;
      v0_q <= 1'b0;
      e0_q <= 1'b0;
      d0_q <= '0;
      v1_q <= 1'b0;
      e1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      rr_q <= rr_d;
      v0_q <= v0_d;
      e0_q <= e0_d;
      d0_q <= d0_d;
      v1_q <= v1_d;
      e1_q <= e1_d;
      d1_q <= d1_d;
    end
  assign p0_resp_valid = v0_q;
  assign p0_resp_err   = e0_q;
  assign p0_resp_rdata = d0_q;
  assign p1_resp_valid = v1_q;
  assign p1_resp_err   = e1_q;
  assign p1_resp_rdata = d1_q;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between two requesters: port 0 is the pipeline load/store unit, port 1 is the DMA/program loader.
- Arbitrates one access per cycle, using round-robin or fixed priority.
- Drives the memory's read/write strobes, address, store data and funct3 field.
- Checks each access for alignment and range, and returns a registered response one cycle after the grant.

Parameters:
- DEPTH, 16384, data memory size in bytes; accesses with addr+size > DEPTH are rejected.
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- ALIGN_CHK, 1, 1 = misaligned halfword/word accesses are rejected; 0 = passed through.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req_valid  in  1  port 0 request present
- p0_req_ready  out  1  port 0 request accepted this cycle
- p0_req_we  in  1  1 = store, 0 = load
- p0_req_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- p0_req_addr  in  32  byte address
- p0_req_wdata  in  32  store data, LSB-aligned
- p0_resp_valid  out  1  one-cycle response pulse
- p0_resp_rdata  out  32  load result (sign/zero-extended by memory); 0 for stores
- p0_resp_err  out  1  access rejected (misaligned or out of range)
- p1_*  (same set and widths as p0_*)  port 1
- mem_read  out  1  to memory mem_read
- mem_write  out  1  to memory mem_write
- mem_addr  out  32  to memory alu_result
- mem_wdata  out  32  to memory rs2_data
- mem_instr  out  32  to memory instruction; funct3 in bits [14:12], all other bits 0
- mem_rdata  in  32  from memory data_mem_data (combinational read)

Behaviour:
- Reset (async, rst_n low):
  - all resp_valid, resp_err, req_ready and mem_read/mem_write are 0; resp_rdata = 0.
  - Round-robin pointer = port 0 (port 0 has first priority after reset).
- Arbitration (combinational each cycle, among ports with req_valid = 1):
  - RR_EN = 1: the port not granted most recently wins a tie; the pointer updates only on a grant.
  - RR_EN = 0: port 0 always wins a tie.
  - Exactly one of p0/p1 req_ready is high when any valid is asserted; none when idle.
- Handshake:
  - A request transfers when valid and ready are both high. There is no back-pressure on responses.
  - A requester that is not granted holds valid and all fields stable; the bench flags any change as a protocol violation.
- Issue cycle:
  - Granted request drives mem_addr, mem_wdata and mem_instr[14:12].
  - mem_read = ~we & ok; mem_write = we & ok.
  - Stores commit at the same rising edge.
- Error checks:
  - ok = in-range & (aligned | ~ALIGN_CHK).
  - In-range: addr + size ≤ DEPTH, with size 1/2/4 from funct3[1:0]; evaluate at 33 bits so there is no wrap-around.
  - Aligned: H requires addr[0] = 0; W requires addr[1:0] = 00.
  - Store funct3 not in {000, 001, 010}, or load funct3 not in {000, 001, 010, 100, 101}: treat as error.
- Error result: no memory strobe; response has err = 1, rdata = 0.
- Response:
  - Registered. At the rising edge ending the issue cycle, the granted port's resp_valid is set for exactly one cycle.
  - rdata captures mem_rdata for loads, 0 for stores.
  - Latency = 1 cycle, with full throughput: back-to-back grants give back-to-back responses.
  - The non-granted port's resp_valid stays 0.
- Idle: when no valid is asserted, mem_* = 0 and mem_instr = 0.
- Store then load to the same address on consecutive cycles (either port): the load returns the new data, because the write commits before the read cycle.
- Reset mid-operation: a pending response is discarded (resp_valid forced to 0). Any store granted in the cycle rst_n falls may or may not commit; the bench does not check it.
- Internal state: RR pointer (1 bit), response valid/err/rdata registers per port.

Test Plan:
- Port 0 SW 0xDEADBEEF @0x100, next cycle LW @0x100 → p0_resp_valid pulses on both, second p0_resp_rdata = 0xDEADBEEF, err = 0.
- Both ports valid continuously for 4 cycles (RR_EN = 1) → grants alternate p0, p1, p0, p1; each port gets 2 responses, each 1 cycle after its grant.
- Same as above with RR_EN = 0 → p0 granted all 4 cycles; p1_req_ready stays 0 and p1 fields stay stable.
- Port 1 LW @0x102 (ALIGN_CHK = 1) → mem_read = 0, p1_resp_err = 1, rdata = 0. Port 1 SH @0x3FFF (DEPTH = 16384) → err = 1, memory unchanged.
- Port 0 SB 0x80 @0x20, then LB and LBU @0x20 → rdata 0xFFFFFF80 then 0x00000080.
- Port 0 load issued, then rst_n pulled low before the next edge → no resp_valid after reset; next grant goes to p0 first.
